// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: shadow/active data registers, prescaled digit scan,
// hex decode with leading-zero blanking, and registered pin outputs of programmable polarity.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  pend,
  output logic                  frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                tick, wrap, wrap_d;
  logic [4*DIGITS-1:0] shadow_data, active_data;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic [3:0]          nibble;
  logic [6:0]          seg_hex;
  logic                blank;
  logic [DIGITS-1:0]   onehot;

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Active only changes at a frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pend        <= 1'b0;
    end else begin
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp_in;
      end
      if (wrap && load) begin
        active_data <= data;
        active_dp   <= dp_in;
      end else if (wrap && pend) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
      end
      if (wrap)
        pend <= 1'b0;
      else if (load)
        pend <= 1'b1;
    end
  end

  always_comb begin
    nibble  = active_data[4*idx +: 4];
    seg_hex = 7'b0000000;
    case (nibble)
      4'h0: seg_hex = 7'b1111110;
      4'h1: seg_hex = 7'b0110000;
      4'h2: seg_hex = 7'b1101101;
      4'h3: seg_hex = 7'b1111001;
      4'h4: seg_hex = 7'b0110011;
      4'h5: seg_hex = 7'b1011011;
      4'h6: seg_hex = 7'b1011111;
      4'h7: seg_hex = 7'b1110000;
      4'h8: seg_hex = 7'b1111111;
      4'h9: seg_hex = 7'b1111011;
      4'hA: seg_hex = 7'b1110111;
      4'hB: seg_hex = 7'b0011111;
      4'hC: seg_hex = 7'b1001110;
      4'hD: seg_hex = 7'b0111101;
      4'hE: seg_hex = 7'b1001111;
      4'hF: seg_hex = 7'b1000111;
    endcase
  end

  // Blank a non-zero digit position when it and every more-significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    if (lz_en && (idx != '0)) begin
      blank = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if ((IW'(i) >= idx) && (active_data[4*i +: 4] != 4'h0))
          blank = 1'b0;
      end
    end
  end

  assign onehot = DIGITS'(1) << idx;

  // frame is delayed one extra stage so it coincides with dig first selecting digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_OFF;
      dp     <= SEG_ACTIVE_LOW;
      dig    <= DIG_OFF;
      wrap_d <= 1'b0;
      frame  <= 1'b0;
    end else begin
      seg    <= (blank ? 7'b0000000 : seg_hex) ^ SEG_OFF;
      dp     <= active_dp[idx] ^ SEG_ACTIVE_LOW;
      dig    <= onehot ^ DIG_OFF;
      wrap_d <= wrap;
      frame  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (default and inverted polarity) checked every cycle
// against a frame-arithmetic reference model under directed and randomized stimulus.
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int DV = 3;
  localparam int FR = D * DV;
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, pend_a, pend_b, frame_a, frame_b;
  logic [3:0] dig_a, dig_b;

  int n_vec = 0, n_err = 0, k = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_adp = '0, m_sdp = '0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .DIV(DV), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg_a), .dp(dp_a), .dig(dig_a), .pend(pend_a), .frame(frame_a));

  seg7_scan_driver #(.DIGITS(D), .DIV(DV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg_b), .dp(dp_b), .dig(dig_b), .pend(pend_b), .frame(frame_b));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic rst_chk();
    chk("rst_seg_a", {1'b0, seg_a}, 8'h00);
    chk("rst_dp_a", {7'b0, dp_a}, 8'h00);
    chk("rst_dig_a", {4'b0, dig_a}, 8'h0F);
    chk("rst_pend_a", {7'b0, pend_a}, 8'h00);
    chk("rst_frame_a", {7'b0, frame_a}, 8'h00);
    chk("rst_seg_b", {1'b0, seg_b}, 8'h7F);
    chk("rst_dp_b", {7'b0, dp_b}, 8'h01);
    chk("rst_dig_b", {4'b0, dig_b}, 8'h00);
    chk("rst_pend_b", {7'b0, pend_b}, 8'h00);
  endtask

  // One clock: digit shown = (k/DV)%D, wrap happens when (k+1) is a multiple of the frame length.
  task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic lz);
    int di;
    logic [6:0] es;
    logic ed, ef, wr;
    logic [3:0] eg;
    load = ld; data = d; dp_in = p; lz_en = lz;
    di = (k / DV) % D;
    es = HEX[4'(m_act >> (4 * di))];
    if (lz && di > 0 && (m_act >> (4 * di)) == 16'h0) es = 7'b0000000;
    ed = m_adp[di];
    eg = 4'(1 << di);
    ef = (k > 0) && (k % FR == 0);
    wr = ((k + 1) % FR) == 0;
    if (wr) begin
      if (ld) begin m_act = d; m_adp = p; end
      else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    if (ld) begin m_sh = d; m_sdp = p; end
    @(posedge clk); #1;
    chk("seg_a", {1'b0, seg_a}, {1'b0, es});
    chk("dp_a", {7'b0, dp_a}, {7'b0, ed});
    chk("dig_a", {4'b0, dig_a}, {4'b0, ~eg});
    chk("pend_a", {7'b0, pend_a}, {7'b0, m_pend});
    chk("frame_a", {7'b0, frame_a}, {7'b0, ef});
    chk("seg_b", {1'b0, seg_b}, {1'b0, ~es});
    chk("dp_b", {7'b0, dp_b}, {7'b0, ~ed});
    chk("dig_b", {4'b0, dig_b}, {4'b0, eg});
    chk("pend_b", {7'b0, pend_b}, {7'b0, m_pend});
    chk("frame_b", {7'b0, frame_b}, {7'b0, ef});
    k++;
    load = 1'b0;
  endtask

  task automatic idle(input int n, input logic lz);
    repeat (n) cyc(1'b0, 16'($urandom), 4'($urandom), lz);
  endtask

  task automatic idle_until(input int ph, input logic lz);
    for (int i = 0; i < FR && (k % FR) != ph; i++) cyc(1'b0, 16'($urandom), 4'($urandom), lz);
  endtask

  task automatic model_clear();
    k = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst_chk();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    // free-running scan of zeros: digit walk and frame pulses
    idle(24, 1'b0);
    // mid-frame load
    idle(5, 1'b0);
    cyc(1'b1, 16'hC0A5, 4'b0100, 1'b0);
    idle(30, 1'b0);
    // two loads in one frame: only the latest ever shows
    idle(2, 1'b0);
    cyc(1'b1, 16'h1111, 4'b0000, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 16'h2222, 4'b0001, 1'b0);
    idle(30, 1'b0);
    // load coincident with wrap, leading-zero suppression on
    idle_until(FR - 1, 1'b1);
    cyc(1'b1, 16'h00F3, 4'b0000, 1'b1);
    idle(14, 1'b1);
    // all-zero value with suppression
    cyc(1'b1, 16'h0000, 4'b1010, 1'b1);
    idle(26, 1'b1);
    // sweep every nibble through digit 0
    for (int n = 0; n < 16; n++) begin
      rd = {12'($urandom_range(0, 1) == 0 ? 0 : $urandom), 4'(n)};
      cyc(1'b1, rd, 4'($urandom), 1'($urandom));
      idle(25, 1'($urandom));
    end
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rd = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00FF) : 16'($urandom);
      cyc(1'($urandom_range(0, 7) == 0), rd, 4'($urandom), 1'($urandom));
    end
    // asynchronous reset mid-frame with data pending
    idle_until(5, 1'b0);
    cyc(1'b1, 16'h9876, 4'hF, 1'b0);
    idle(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle(2 * FR, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
